// File: rtl/instr_sequencer.sv
// Instruction sequencer: latches one 16-bit instruction at a time and steps the
// datapath strobes through a fixed per-opcode state sequence.
module instr_sequencer #(
  parameter bit IMM_SEXT = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        s,
  input  logic [15:0] instr,
  output logic        w,
  output logic        done,
  output logic        illegal,
  output logic [2:0]  nsel,
  output logic [2:0]  rnum,
  output logic        loada,
  output logic        loadb,
  output logic        loadc,
  output logic        loads,
  output logic        write,
  output logic        asel,
  output logic        bsel,
  output logic [1:0]  vsel,
  output logic [1:0]  ALUop,
  output logic [1:0]  shift,
  output logic [15:0] sximm8
);

  typedef enum logic [2:0] {
    S_WAIT, S_DECODE, S_GET_A, S_GET_B, S_EXEC, S_WRITE, S_WIMM
  } state_t;

  typedef struct packed {
    logic       w;
    logic       done;
    logic [2:0] nsel;
    logic [2:0] rnum;
    logic       loada;
    logic       loadb;
    logic       loadc;
    logic       loads;
    logic       write;
    logic       asel;
    logic       bsel;
    logic [1:0] vsel;
    logic [1:0] aluop;
    logic [1:0] shift;
  } ctl_t;

  state_t      state, ns;
  logic [15:0] ir, ir_nxt;
  logic        accept;
  ctl_t        c;

  // First state after DECODE; S_WAIT doubles as the "undecodable" marker.
  function automatic state_t first_state(input logic [15:0] i);
    case ({i[15:13], i[12:11]})
      5'b110_10:                     first_state = S_WIMM;
      5'b110_00, 5'b101_11:          first_state = S_GET_B;
      5'b101_00, 5'b101_01, 5'b101_10: first_state = S_GET_A;
      default:                       first_state = S_WAIT;
    endcase
  endfunction

  function automatic state_t next_state(input state_t st, input logic [15:0] i, input logic go);
    case (st)
      S_WAIT:   next_state = go ? S_DECODE : S_WAIT;
      S_DECODE: next_state = first_state(i);
      S_GET_A:  next_state = S_GET_B;
      S_GET_B:  next_state = S_EXEC;
      S_EXEC:   next_state = (i[15:11] == 5'b101_01) ? S_WAIT : S_WRITE;
      default:  next_state = S_WAIT;
    endcase
  endfunction

  function automatic ctl_t outputs(input state_t st, input logic [15:0] i);
    ctl_t o;
    o = '0;
    case (st)
      S_WAIT:   o.w = 1'b1;
      S_DECODE: o.done = (first_state(i) == S_WAIT);
      S_GET_A:  begin o.nsel = 3'b001; o.loada = 1'b1; end
      S_GET_B:  begin o.nsel = 3'b100; o.loadb = 1'b1; o.shift = i[4:3]; end
      S_EXEC: begin
        o.shift = i[4:3];
        if (i[15:13] == 3'b110) begin
          o.asel = 1'b1; o.loadc = 1'b1;
        end else if (i[12:11] == 2'b01) begin
          o.aluop = 2'b01; o.loads = 1'b1; o.done = 1'b1;
        end else begin
          // MVN zeroes A; ADD/AND pass op straight through as the ALU code
          o.asel  = (i[12:11] == 2'b11);
          o.aluop = i[12:11];
          o.loadc = 1'b1;
        end
      end
      S_WRITE:  begin o.nsel = 3'b010; o.write = 1'b1; o.done = 1'b1; end
      S_WIMM:   begin o.nsel = 3'b001; o.vsel = 2'b10; o.write = 1'b1; o.done = 1'b1; end
      default:  o = '0;
    endcase
    case (o.nsel)
      3'b001:  o.rnum = i[10:8];
      3'b010:  o.rnum = i[7:5];
      3'b100:  o.rnum = i[2:0];
      default: o.rnum = 3'b000;
    endcase
    return o;
  endfunction

  always_comb begin
    accept = (state == S_WAIT) && s;
    ir_nxt = accept ? instr : ir;
    ns     = next_state(state, ir, s);
  end

  // Outputs are registered from the next state so they line up with the state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_WAIT;
      ir      <= 16'h0000;
      illegal <= 1'b0;
      c       <= outputs(S_WAIT, 16'h0000);
    end else begin
      state <= ns;
      ir    <= ir_nxt;
      c     <= outputs(ns, ir_nxt);
      if (accept) illegal <= (first_state(instr) == S_WAIT);
    end
  end

  assign w     = c.w;
  assign done  = c.done;
  assign nsel  = c.nsel;
  assign rnum  = c.rnum;
  assign loada = c.loada;
  assign loadb = c.loadb;
  assign loadc = c.loadc;
  assign loads = c.loads;
  assign write = c.write;
  assign asel  = c.asel;
  assign bsel  = c.bsel;
  assign vsel  = c.vsel;
  assign ALUop = c.aluop;
  assign shift = c.shift;

  assign sximm8 = IMM_SEXT ? {{8{ir[7]}}, ir[7:0]} : {8'h00, ir[7:0]};

endmodule

// File: doc/instr_sequencer.md
INSTR_SEQUENCER -- requirements
Module: instr_sequencer

Interface
REQ-001 Parameter IMM_SEXT, default 1: 1 = sign-extend imm8 to 16 bits; 0 = zero-extend.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 reset  input  1  synchronous, active-high; sampled only at the clk rising edge.
REQ-004 s  input  1  start request; sampled only in WAIT.
REQ-005 instr  input  16  instruction; [15:13] opcode, [12:11] op, [10:8] Rn, [7:5] Rd, [4:3] shift, [2:0] Rm, [7:0] imm8.
REQ-006 w  output  1  idle indicator; 1 only in WAIT.
REQ-007 done  output  1  one-cycle pulse in the final state of each instruction.
REQ-008 illegal  output  1  sticky flag for an undecodable instruction.
REQ-009 nsel  output  3  one-hot register-file select; 001 = Rn, 010 = Rd, 100 = Rm, 000 = none.
REQ-010 rnum  output  3  register number muxed from the latched instruction by nsel; 0 when nsel = 000.
REQ-011 loada, loadb, loadc, loads, write  output  1 each  datapath load and write strobes.
REQ-012 asel, bsel  output  1 each  asel = 1 forces the ALU A operand to 0; bsel = 1 selects sximm5 (unused, held 0).
REQ-013 vsel  output  2  writeback source; 00 = datapath C, 10 = sximm8.
REQ-014 ALUop  output  2  ALU operation; 00 add, 01 subtract, 10 and, 11 not-B.
REQ-015 shift  output  2  shifter control, taken from latched instr[4:3].
REQ-016 sximm8  output  16  imm8 extended per IMM_SEXT.

Function
REQ-017 In WAIT with s = 1, the block SHALL latch instr into an internal IR and move to DECODE; instr is ignored in all other states and cycles.
REQ-018 All outputs SHALL be Moore functions of the state and the IR; every strobe not listed for a state is 0.
REQ-019 States SHALL be WAIT, DECODE, GET_A, GET_B, EXEC, WRITE, WIMM.
REQ-020 MOV imm (opcode 110, op 10) SHALL follow DECODE -> WIMM -> WAIT.
  - WIMM: nsel = 001, vsel = 10, write = 1, done = 1.
REQ-021 MOV reg (opcode 110, op 00) SHALL follow DECODE -> GET_B -> EXEC -> WRITE -> WAIT.
  - EXEC: asel = 1, ALUop = 00, loadc = 1.
REQ-022 ADD (opcode 101, op 00) and AND (opcode 101, op 10) SHALL follow DECODE -> GET_A -> GET_B -> EXEC -> WRITE -> WAIT.
  - EXEC: ALUop = IR op, loadc = 1.
REQ-023 CMP (opcode 101, op 01) SHALL follow DECODE -> GET_A -> GET_B -> EXEC -> WAIT.
  - EXEC: ALUop = 01, loads = 1, loadc = 0, done = 1.
REQ-024 MVN (opcode 101, op 11) SHALL follow DECODE -> GET_B -> EXEC -> WRITE -> WAIT.
  - EXEC: asel = 1, ALUop = 11, loadc = 1.
REQ-025 State outputs SHALL be as follows:
  - GET_A: nsel = 001, loada = 1.
  - GET_B: nsel = 100, loadb = 1.
  - WRITE: nsel = 010, vsel = 00, write = 1, done = 1.
REQ-026 shift SHALL equal IR[4:3] in GET_B and EXEC, and 00 otherwise.
REQ-027 Any other opcode/op combination in DECODE SHALL set illegal = 1, pulse done for that DECODE cycle, and return to WAIT with no load or write strobe asserted.
REQ-028 illegal SHALL clear when the next instruction is accepted from WAIT.
REQ-029 Latency from the s-sampling edge to the done cycle SHALL be:
  - MOV imm: 2 cycles.
  - MOV reg, MVN, CMP: 4 cycles.
  - ADD, AND: 5 cycles.
  - illegal: 1 cycle.
REQ-030 Holding s = 1 continuously SHALL start a new instruction on the first WAIT cycle after each completion (one WAIT cycle minimum between instructions).
REQ-031 sximm8 SHALL be combinational from the IR and stable for the whole instruction.

Reset
REQ-032 reset = 1 at a clock edge SHALL force WAIT from any state, including mid-instruction.
REQ-033 Output values while in WAIT after reset: w = 1, done = 0, illegal = 0, all strobes 0, nsel = 000, ALUop = 00, vsel = 00, shift = 00.
REQ-034 The IR SHALL reset to 16'h0000, so sximm8 = 0.
REQ-035 reset SHALL take priority over s in the same cycle.

Verification
REQ-036 MOV R2,#-5 (instr 16'hD2FB), s pulse -> WIMM two cycles later with write = 1, nsel = 001, rnum = 2, sximm8 = 16'hFFFB, done = 1; w = 1 on the following cycle.
REQ-037 ADD R1,R2,R3 (instr 16'hA223) -> cycle sequence GET_A(loada), GET_B(loadb), EXEC(loadc, ALUop = 00), WRITE(write, rnum = 1); done exactly 5 cycles after acceptance.
REQ-038 CMP R0,R1 (instr 16'hA801) -> EXEC with loads = 1, loadc = 0, ALUop = 01, done = 1; write never asserted.
REQ-039 Illegal opcode 16'h0000 -> illegal = 1 and done = 1 one cycle after acceptance; illegal clears when a valid MOV imm is next accepted.
REQ-040 reset asserted during the EXEC of an ADD -> WAIT on the next cycle, WRITE never reached, all strobes 0.
REQ-041 instr changed in the cycle after acceptance -> rnum, ALUop and sximm8 still reflect the originally latched instruction.
